// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the five-stage core.
// Turns per-stage stall requests into a stall vector with a bubble flush.
// Ranks commit-time exception, ERTN and EX-stage branch redirects, and
// drives the fetch redirect PC. After a trap redirect it holds the front
// end flushed for FLUSH_HOLD cycles, and it parks the core while an IDLE
// instruction waits for an interrupt.
// Optional feature: define PIPE_CTRL_PERF_EN to add the performance counters
// perf_stall_cycles_o, perf_flush_cnt_o and perf_idle_cycles_o.
module pipe_ctrl #(
    parameter int FLUSH_HOLD = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        excp_i,
    input  logic        tlbrefill_i,
    input  logic [31:0] eentry_i,
    input  logic [31:0] tlbrentry_i,
    input  logic        ertn_i,
    input  logic [31:0] era_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        idle_i,
    input  logic        int_pending_i,
    output logic [5:0]  stall_o,
    output logic [5:0]  flush_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        idle_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles_o,
    output logic [31:0] perf_flush_cnt_o,
    output logic [31:0] perf_idle_cycles_o
`endif
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        IDLE = 2'd2
    } state_t;

    localparam logic [1:0] HOLD_N = 2'(FLUSH_HOLD);

    // Trap flush clears IF/ID..MEM/WB; front-end flush clears IF/ID and ID/EX.
    localparam logic [5:0] FL_TRAP  = 6'b011110;
    localparam logic [5:0] FL_FRONT = 6'b000110;

    state_t      state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic        idle_q;
    logic [5:0]  stall_c, flush_c, stall_req_v, flush_req_v;
    logic        redir_c;
    logic [31:0] pc_c;
    logic [31:0] trap_pc;

    // Highest requesting stage k: hold bits k..0, bubble into register k+1.
    always_comb begin
        stall_req_v = 6'b000000;
        flush_req_v = 6'b000000;
        if (stallreq_mem) begin
            stall_req_v = 6'b011111;
            flush_req_v = 6'b100000;
        end else if (stallreq_ex) begin
            stall_req_v = 6'b001111;
            flush_req_v = 6'b010000;
        end else if (stallreq_id) begin
            stall_req_v = 6'b000111;
            flush_req_v = 6'b001000;
        end else if (stallreq_if) begin
            stall_req_v = 6'b000011;
            flush_req_v = 6'b000100;
        end
    end

    assign trap_pc = tlbrefill_i ? tlbrentry_i : eentry_i;

    // Next-state, hold counter and combinational pipeline controls.
    always_comb begin
        stall_c   = 6'b000000;
        flush_c   = 6'b000000;
        redir_c   = 1'b0;
        pc_c      = 32'h0;
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            RUN: begin
                if (excp_i || ertn_i) begin
                    redir_c   = 1'b1;
                    pc_c      = excp_i ? trap_pc : era_i;
                    flush_c   = FL_TRAP;
                    state_nxt = (HOLD_N != 2'd0) ? HOLD : RUN;
                    cnt_nxt   = (HOLD_N != 2'd0) ? 2'd1 : 2'd0;
                end else begin
                    // A branch is only taken when EX is not being held.
                    if (branch_i && !stall_req_v[3]) begin
                        redir_c = 1'b1;
                        pc_c    = branch_target_i;
                        flush_c = FL_FRONT;
                    end else begin
                        stall_c = stall_req_v;
                        flush_c = flush_req_v;
                    end
                    if (idle_i) begin
                        state_nxt = IDLE;
                    end
                end
            end
            HOLD: begin
                if (excp_i) begin
                    redir_c = 1'b1;
                    pc_c    = trap_pc;
                    flush_c = FL_TRAP;
                    cnt_nxt = 2'd1;
                end else begin
                    flush_c = FL_FRONT;
                    if (cnt >= HOLD_N) begin
                        state_nxt = RUN;
                        cnt_nxt   = 2'd0;
                    end else begin
                        cnt_nxt = cnt + 2'd1;
                    end
                end
            end
            IDLE: begin
                if (excp_i) begin
                    redir_c   = 1'b1;
                    pc_c      = trap_pc;
                    flush_c   = FL_TRAP;
                    state_nxt = (HOLD_N != 2'd0) ? HOLD : RUN;
                    cnt_nxt   = (HOLD_N != 2'd0) ? 2'd1 : 2'd0;
                end else begin
                    stall_c = 6'b000011;
                    flush_c = 6'b000100;
                    if (int_pending_i) begin
                        state_nxt = RUN;
                    end
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = 2'd0;
            end
        endcase
    end

    // Controls are forced low while reset is asserted.
    assign stall_o       = rst ? stall_c : 6'b000000;
    assign flush_o       = rst ? flush_c : 6'b000000;
    assign redirect_o    = rst ? redir_c : 1'b0;
    assign redirect_pc_o = rst ? pc_c : 32'h0;
    assign idle_o        = idle_q;

    // State register, hold counter and registered idle flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= RUN;
            cnt    <= 2'd0;
            idle_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idle_q <= (state_nxt == IDLE);
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Free-running wrap-around performance counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_cycles_o <= 32'h0;
            perf_flush_cnt_o    <= 32'h0;
            perf_idle_cycles_o  <= 32'h0;
        end else begin
            if (stall_c[0] && state != IDLE) begin
                perf_stall_cycles_o <= perf_stall_cycles_o + 32'h1;
            end
            if (redir_c) begin
                perf_flush_cnt_o <= perf_flush_cnt_o + 32'h1;
            end
            if (state == IDLE) begin
                perf_idle_cycles_o <= perf_idle_cycles_o + 32'h1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl (FLUSH_HOLD = 1).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        excp_i, tlbrefill_i, ertn_i, branch_i, idle_i, int_pending_i;
    logic [31:0] eentry_i, tlbrentry_i, era_i, branch_target_i;
    logic [5:0]  stall_o, flush_o;
    logic        redirect_o, idle_o;
    logic [31:0] redirect_pc_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles_o, perf_flush_cnt_o, perf_idle_cycles_o;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.FLUSH_HOLD(1)) dut (
        .clk(clk), .rst(rst),
        .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
        .excp_i(excp_i), .tlbrefill_i(tlbrefill_i),
        .eentry_i(eentry_i), .tlbrentry_i(tlbrentry_i),
        .ertn_i(ertn_i), .era_i(era_i),
        .branch_i(branch_i), .branch_target_i(branch_target_i),
        .idle_i(idle_i), .int_pending_i(int_pending_i),
        .stall_o(stall_o), .flush_o(flush_o),
        .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
        .idle_o(idle_o)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cycles_o(perf_stall_cycles_o),
        .perf_flush_cnt_o(perf_flush_cnt_o),
        .perf_idle_cycles_o(perf_idle_cycles_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Sample all outputs at the falling edge, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic [5:0] s, input logic [5:0] f,
                       input logic r, input logic [31:0] pc, input logic id);
        @(negedge clk);
        chk({tag, ".stall"}, 32'(stall_o), 32'(s));
        chk({tag, ".flush"}, 32'(flush_o), 32'(f));
        chk({tag, ".redir"}, 32'(redirect_o), 32'(r));
        chk({tag, ".pc"}, redirect_pc_o, pc);
        chk({tag, ".idle"}, 32'(idle_o), 32'(id));
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        excp_i = 0; tlbrefill_i = 0; ertn_i = 0; branch_i = 0;
        idle_i = 0; int_pending_i = 0;
    endtask

    initial begin
        clr();
        rst = 1'b0;
        eentry_i = 32'h1c008000; tlbrentry_i = 32'h1c00f000;
        era_i = 32'h1c000440;    branch_target_i = 32'h1c000100;
        // Reset: outputs held low even with active requests.
        stallreq_ex = 1; excp_i = 1;
        @(posedge clk); #1;
        cyc("rst", 6'b0, 6'b0, 0, 32'h0, 0);
        clr(); rst = 1'b1;
        cyc("quiet", 6'b0, 6'b0, 0, 32'h0, 0);

        // EX stall for three cycles, then release.
        stallreq_ex = 1;
        for (int i = 0; i < 3; i++) cyc("stall_ex", 6'b001111, 6'b010000, 0, 32'h0, 0);
        clr();
        cyc("stall_off", 6'b0, 6'b0, 0, 32'h0, 0);
        stallreq_if = 1;
        cyc("stall_if", 6'b000011, 6'b000100, 0, 32'h0, 0);
        stallreq_id = 1; stallreq_mem = 1;
        cyc("stall_mem", 6'b011111, 6'b100000, 0, 32'h0, 0);
        clr();

        // Exception with stall request: redirect wins, then one HOLD cycle.
        excp_i = 1; stallreq_id = 1;
        cyc("excp", 6'b0, 6'b011110, 1, 32'h1c008000, 0);
        clr(); branch_i = 1; stallreq_ex = 1;
        cyc("hold", 6'b0, 6'b000110, 0, 32'h0, 0);
        clr(); stallreq_if = 1;
        cyc("after_hold", 6'b000011, 6'b000100, 0, 32'h0, 0);
        clr();

        // All three redirects with TLB refill.
        excp_i = 1; ertn_i = 1; branch_i = 1; tlbrefill_i = 1;
        cyc("prio_tlbr", 6'b0, 6'b011110, 1, 32'h1c00f000, 0);
        clr();
        cyc("prio_hold", 6'b0, 6'b000110, 0, 32'h0, 0);

        // ERTN beats branch.
        ertn_i = 1; branch_i = 1;
        cyc("ertn", 6'b0, 6'b011110, 1, 32'h1c000440, 0);
        clr();
        cyc("ertn_hold", 6'b0, 6'b000110, 0, 32'h0, 0);

        // Branch blocked by MEM stall, then taken.
        branch_i = 1; stallreq_mem = 1;
        cyc("br_blocked", 6'b011111, 6'b100000, 0, 32'h0, 0);
        stallreq_mem = 0;
        cyc("br_taken", 6'b0, 6'b000110, 1, 32'h1c000100, 0);
        stallreq_id = 1; branch_target_i = 32'h1c000200;
        cyc("br_over_id", 6'b0, 6'b000110, 1, 32'h1c000200, 0);
        clr(); stallreq_if = 1;
        cyc("br_no_hold", 6'b000011, 6'b000100, 0, 32'h0, 0);
        clr();

        // IDLE: commit cycle passes through, five parked cycles, interrupt wakes.
        idle_i = 1;
        cyc("idle_commit", 6'b0, 6'b0, 0, 32'h0, 0);
        clr();
        for (int i = 0; i < 4; i++) cyc("idle_park", 6'b000011, 6'b000100, 0, 32'h0, 1);
        int_pending_i = 1;
        cyc("idle_park5", 6'b000011, 6'b000100, 0, 32'h0, 1);
        clr();
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_idle", perf_idle_cycles_o, 32'd5);
`endif
        cyc("idle_wake", 6'b0, 6'b0, 0, 32'h0, 0);

        // Exception while parked leaves IDLE.
        idle_i = 1;
        cyc("idle2_commit", 6'b0, 6'b0, 0, 32'h0, 0);
        clr();
        cyc("idle2_park", 6'b000011, 6'b000100, 0, 32'h0, 1);
        excp_i = 1;
        cyc("idle2_excp", 6'b0, 6'b011110, 1, 32'h1c008000, 1);
        clr();
        cyc("idle2_hold", 6'b0, 6'b000110, 0, 32'h0, 0);

        // Exception with IDLE commit: IDLE not entered.
        excp_i = 1; idle_i = 1;
        cyc("excp_idle", 6'b0, 6'b011110, 1, 32'h1c008000, 0);
        clr();
        cyc("excp_idle_h", 6'b0, 6'b000110, 0, 32'h0, 0);
        cyc("excp_idle_r", 6'b0, 6'b0, 0, 32'h0, 0);

        // Reset asserted during HOLD.
        excp_i = 1;
        cyc("rh_excp", 6'b0, 6'b011110, 1, 32'h1c008000, 0);
        clr(); rst = 1'b0;
        cyc("rh_rst", 6'b0, 6'b0, 0, 32'h0, 0);
        rst = 1'b1;
        cyc("rh_release", 6'b0, 6'b0, 0, 32'h0, 0);
        stallreq_ex = 1;
        cyc("rh_run", 6'b001111, 6'b010000, 0, 32'h0, 0);
        clr();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
